exec_stage: RTL
===============

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the datapath width in bits.
REQ-002 SHALL have parameter REGW, default 2, the register-address width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, ID/EX holds a valid instruction.
REQ-006 SHALL have port in_op, input, 3, operation code (encodings in REQ-015).
REQ-007 SHALL have ports in_a and in_b, input, WIDTH each, operand values read in ID.
REQ-008 SHALL have ports in_dest (input, REGW), the destination register, and in_wb (input, 1), the register-write enable.
REQ-009 SHALL have ports sel1 and sel2, input, 2 each, forwarding selects for operands A and B.
REQ-010 SHALL have ports mem_fwd and wb_fwd, input, WIDTH each, forwarded results from MEM and WB.
REQ-011 SHALL have port flush, input, 1, kill the instruction in flight.
REQ-012 SHALL have port stall, output, 1, upstream holds ID/EX while high (combinational).
REQ-013 SHALL have EX/MEM outputs ex_valid (1), ex_result (WIDTH), ex_zero (1), ex_dest (REGW) and ex_wb (1), all registered.

Function
REQ-014 SHALL select each operand as follows: sel 00 gives in_a/in_b, 01 gives mem_fwd, 10 gives wb_fwd, 11 gives in_a/in_b.
REQ-015 SHALL decode in_op as: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed two's-complement, result 1 or 0), 101 MUL, 110 PASSB, 111 NOP.
REQ-016 SHALL discard carry and borrow for ADD and SUB, wrapping modulo 2^WIDTH.
REQ-017 SHALL give MUL the low WIDTH bits of the unsigned product.
REQ-018 SHALL complete single-cycle ops (all except MUL) in one cycle: when accepted, ex_* update at the next edge, with ex_valid=1 (0 for NOP) and ex_zero=(ex_result==0).
REQ-019 SHALL implement a two-state FSM with states IDLE and BUSY.
REQ-020 SHALL, in IDLE with in_valid=1 and MUL, latch the forwarded A into a multiplicand register and B into a multiplier register, clear the accumulator and count, and go to BUSY.
REQ-021 SHALL, in BUSY, each cycle add the multiplicand to the accumulator if multiplier bit 0 is 1, shift the multiplicand left by 1 and the multiplier right by 1, and increment count.
REQ-022 SHALL, in BUSY with count==WIDTH-1, write the final accumulator, dest and wb to ex_* with ex_valid=1 and return to IDLE.
REQ-023 SHALL make MUL latency WIDTH+1 cycles from acceptance to ex_valid.
REQ-024 SHALL drive stall = (IDLE & in_valid & op==MUL & ~flush) | (BUSY & count!=WIDTH-1 & ~flush).
REQ-025 SHALL ignore in_* and sel* while BUSY, using only the latched operands.
REQ-026 SHALL drive ex_valid=0 (a bubble) on every edge while BUSY except the final one.
REQ-027 SHALL give flush priority over everything: at the next edge ex_valid=0, any BUSY multiply is aborted to IDLE, and no result is written.
REQ-028 SHALL clear ex_valid and leave the other ex_* fields unchanged when in_valid=0 in IDLE.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state=IDLE, count=0, ex_valid=0, ex_result=0, ex_zero=0, ex_dest=0, ex_wb=0, and hence stall=0.
REQ-030 SHALL discard any multiply in progress when reset is asserted mid-operation, producing no result after release.

Verification
REQ-031 SHALL test ADD a=8'hF0 b=8'h20 sel=00/00 -> next edge ex_result=8'h10, ex_zero=0, ex_valid=1.
REQ-032 SHALL test SUB a=5 b=9 with sel1=01 mem_fwd=9 -> ex_result=0, ex_zero=1.
REQ-033 SHALL test SLT a=8'h80 b=8'h01 -> ex_result=1; and with sel2=10 wb_fwd=8'h80, a=1 -> ex_result=0.
REQ-034 SHALL test MUL 13*11, WIDTH=8 -> stall high for 8 cycles, low in the 9th; ex_valid=0 for 8 edges, then ex_result=8'h8F with ex_valid=1 exactly once.
REQ-035 SHALL test MUL with flush asserted in BUSY cycle 3 -> stall drops the same cycle, ex_valid stays 0, and FSM is IDLE next cycle.
REQ-036 SHALL test rst_n pulsed low during BUSY -> all outputs 0 immediately, and no ex_valid after release.

Source files
------------

// File: rtl/exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : exec_stage
// Brief    : Execute stage of a small in-order pipeline. Operand forwarding
//            muxes, a single-cycle ALU (ADD/SUB/AND/OR/SLT/PASSB/NOP) and a
//            multi-cycle shift-add multiplier that holds the ID/EX register
//            through a combinational stall while it iterates.
// Revision : 1.0 - initial release
// ============================================================================
module exec_stage #(
    parameter int WIDTH = 8,
    parameter int REGW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [REGW-1:0]  in_dest,
    input  logic             in_wb,
    input  logic [1:0]       sel1,
    input  logic [1:0]       sel2,
    input  logic [WIDTH-1:0] mem_fwd,
    input  logic [WIDTH-1:0] wb_fwd,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_result,
    output logic             ex_zero,
    output logic [REGW-1:0]  ex_dest,
    output logic             ex_wb
);

    // ------------------------------------------------------------------------
    // Operation encodings
    // ------------------------------------------------------------------------
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_SLT   = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    // Iteration counter runs 0..WIDTH-1; the last value marks the final step.
    localparam int              CNTW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q;
    logic [CNTW-1:0]   count_q;
    logic [WIDTH-1:0]  mcand_q;     // multiplicand, shifts left each step
    logic [WIDTH-1:0]  mplier_q;    // multiplier, shifts right each step
    logic [WIDTH-1:0]  acc_q;       // running partial product
    logic [REGW-1:0]   mdest_q;     // destination captured with the multiply
    logic              mwb_q;       // write enable captured with the multiply

    // ------------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic [WIDTH-1:0]  alu_d;
    logic [WIDTH-1:0]  acc_d;
    logic              last_step;
    logic              mul_req;

    // Forwarding muxes: 01 takes the MEM result, 10 the WB result, otherwise
    // the value read in ID (11 is treated as "no forwarding").
    always_comb begin
        unique case (sel1)
            2'b01:   opa = mem_fwd;
            2'b10:   opa = wb_fwd;
            default: opa = in_a;
        endcase
        unique case (sel2)
            2'b01:   opb = mem_fwd;
            2'b10:   opb = wb_fwd;
            default: opb = in_b;
        endcase
    end

    // Single-cycle ALU; MUL and NOP produce zero here (MUL is iterative).
    always_comb begin
        alu_d = '0;
        unique case (in_op)
            OP_ADD:   alu_d = opa + opb;
            OP_SUB:   alu_d = opa - opb;
            OP_AND:   alu_d = opa & opb;
            OP_OR:    alu_d = opa | opb;
            OP_SLT:   alu_d[0] = ($signed(opa) < $signed(opb));
            OP_PASSB: alu_d = opb;
            default:  alu_d = '0;
        endcase
    end

    // One shift-add step: conditionally accumulate the shifted multiplicand.
    // Only the low WIDTH product bits are kept, so truncating the shifted
    // multiplicand never loses a bit that matters.
    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    assign last_step = (count_q == CNT_LAST);
    assign mul_req   = in_valid && (in_op == OP_MUL);

    // Hold upstream while a multiply is being accepted or still iterating;
    // the final iteration releases it so the next instruction can enter.
    // A flush always releases the hold in the same cycle.
    assign stall = ~flush & (((state_q == IDLE) & mul_req) |
                             ((state_q == BUSY) & ~last_step));

    // Pipeline register and multiplier FSM; flush dominates every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            mdest_q   <= '0;
            mwb_q     <= 1'b0;
            ex_valid  <= 1'b0;
            ex_result <= '0;
            ex_zero   <= 1'b0;
            ex_dest   <= '0;
            ex_wb     <= 1'b0;
        end else if (flush) begin
            // Kill whatever is in flight; the result fields keep their values
            // but are not marked valid.
            state_q  <= IDLE;
            ex_valid <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!in_valid) begin
                        ex_valid <= 1'b0;
                    end else if (in_op == OP_MUL) begin
                        mcand_q  <= opa;
                        mplier_q <= opb;
                        acc_q    <= '0;
                        count_q  <= '0;
                        mdest_q  <= in_dest;
                        mwb_q    <= in_wb;
                        ex_valid <= 1'b0;
                        state_q  <= BUSY;
                    end else begin
                        // NOP travels as a bubble and never requests a write.
                        ex_valid  <= (in_op != OP_NOP);
                        ex_result <= alu_d;
                        ex_zero   <= (alu_d == '0);
                        ex_dest   <= in_dest;
                        ex_wb     <= in_wb & (in_op != OP_NOP);
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CNTW'(1);
                    if (last_step) begin
                        ex_valid  <= 1'b1;
                        ex_result <= acc_d;
                        ex_zero   <= (acc_d == '0);
                        ex_dest   <= mdest_q;
                        ex_wb     <= mwb_q;
                        state_q   <= IDLE;
                    end else begin
                        ex_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ex_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
